// File: rtl/ram_bus_arbiter_pkg.sv
// rtl/ram_bus_arbiter_pkg.sv - shared state encodings, master IDs and arbitration helper
package ram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUE  = 2'd1,
    ARB_RDWAIT = 2'd2
  } arb_state_e;

  localparam logic MASTER_M0 = 1'b0;
  localparam logic MASTER_M1 = 1'b1;

  localparam int DEFAULT_STARVE_LIMIT = 4;

  // m1 wins when it is alone, or when m0 has starved it for too long
  function automatic logic pick_m1(input logic m0_req, input logic m1_req, input logic starved);
    return m1_req && (!m0_req || starved);
  endfunction

endpackage

// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - two-master RAM bus arbiter, m0 priority with m1 starvation guard
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [2:0]  i_m0_len,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [2:0]  i_m1_len,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_ram_address,
  output logic [31:0] o_ram_wr_data,
  output logic        o_ram_wr_enable,
  output logic [2:0]  o_ram_write_length,
  input  logic [31:0] i_ram_read_data,
  output logic        o_busy
);

  localparam logic [2:0] RD_LAT     = 3'(READ_LATENCY);
  localparam logic [2:0] STARVE_CAP = 3'(STARVE_LIMIT);

  arb_state_e  state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic [2:0]  lat_q, lat_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  len_q, len_d;
  logic        wr_en_q, wr_en_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        rv0_q, rv0_d, rv1_q, rv1_d;
  logic        busy_q, busy_d;
  logic        win_m1;
  logic        last_rd;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lat_d    = lat_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    len_d    = len_q;
    wr_en_d  = 1'b0;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    last_rd  = 1'b0;
    win_m1   = pick_m1(i_m0_req, i_m1_req, starve_q >= STARVE_CAP);

    case (state_q)
      ARB_IDLE: begin
        if (i_m0_req || i_m1_req) begin
          state_d = ARB_ISSUE;
          owner_d = win_m1 ? MASTER_M1 : MASTER_M0;
          we_d    = win_m1 ? i_m1_we    : i_m0_we;
          addr_d  = win_m1 ? i_m1_addr  : i_m0_addr;
          wdata_d = win_m1 ? i_m1_wdata : i_m0_wdata;
          len_d   = win_m1 ? i_m1_len   : i_m0_len;
          wr_en_d = we_d;
          gnt0_d  = !win_m1;
          gnt1_d  = win_m1;
          if (win_m1) begin
            starve_d = 3'd0;
          end else if (i_m1_req && starve_q != 3'd7) begin
            starve_d = starve_q + 3'd1;
          end
        end
      end
      ARB_ISSUE: begin
        if (we_q) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_RDWAIT;
          lat_d   = 3'd1;
          last_rd = (RD_LAT == 3'd1);
        end
      end
      ARB_RDWAIT: begin
        if (lat_q == RD_LAT) begin
          state_d = ARB_IDLE;
        end else begin
          lat_d   = lat_q + 3'd1;
          last_rd = (lat_d == RD_LAT);
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // m1 is only considered starved while it keeps asking without a break
    if (!i_m1_req) begin
      starve_d = 3'd0;
    end

    rv0_d  = last_rd && (owner_q == MASTER_M0);
    rv1_d  = last_rd && (owner_q == MASTER_M1);
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_q  <= ARB_IDLE;
      starve_q <= 3'd0;
      lat_q    <= 3'd0;
      owner_q  <= MASTER_M0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      len_q    <= 3'd0;
      wr_en_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lat_q    <= lat_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      len_q    <= len_d;
      wr_en_q  <= wr_en_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      busy_q   <= busy_d;
    end
  end

  assign o_m0_gnt           = gnt0_q;
  assign o_m1_gnt           = gnt1_q;
  assign o_m0_rvalid        = rv0_q;
  assign o_m1_rvalid        = rv1_q;
  // the RAM returns data in the strobe cycle itself, so it is steered, not stored
  assign o_m0_rdata         = rv0_q ? i_ram_read_data : 32'd0;
  assign o_m1_rdata         = rv1_q ? i_ram_read_data : 32'd0;
  assign o_ram_address      = addr_q;
  assign o_ram_wr_data      = wdata_q;
  assign o_ram_wr_enable    = wr_en_q;
  assign o_ram_write_length = len_q;
  assign o_busy             = busy_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb/tb_ram_bus_arbiter.sv - directed and random checks of two arbiters (read latency 1 and 3)
module tb_ram_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_len, m1_len;

  logic        gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], wen [2], busy [2];
  logic [31:0] rd0 [2], rd1 [2], raddr [2], rwdata [2], ram_rd [2];
  logic [2:0]  rlen [2];

  ram_bus_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) u_dut_l1 (
    .clk(clk), .i_reset_n(rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_len(m0_len),
    .o_m0_gnt(gnt0[0]), .o_m0_rvalid(rv0[0]), .o_m0_rdata(rd0[0]),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_len(m1_len),
    .o_m1_gnt(gnt1[0]), .o_m1_rvalid(rv1[0]), .o_m1_rdata(rd1[0]),
    .o_ram_address(raddr[0]), .o_ram_wr_data(rwdata[0]), .o_ram_wr_enable(wen[0]),
    .o_ram_write_length(rlen[0]), .i_ram_read_data(ram_rd[0]), .o_busy(busy[0])
  );

  ram_bus_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) u_dut_l3 (
    .clk(clk), .i_reset_n(rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_len(m0_len),
    .o_m0_gnt(gnt0[1]), .o_m0_rvalid(rv0[1]), .o_m0_rdata(rd0[1]),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_len(m1_len),
    .o_m1_gnt(gnt1[1]), .o_m1_rvalid(rv1[1]), .o_m1_rdata(rd1[1]),
    .o_ram_address(raddr[1]), .o_ram_wr_data(rwdata[1]), .o_ram_wr_enable(wen[1]),
    .o_ram_write_length(rlen[1]), .i_ram_read_data(ram_rd[1]), .o_busy(busy[1])
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // reference model: one transaction record per arbiter, timed by edge number
  int          free_at [2], ts [2], starve [2];
  bit          have [2], w1 [2], twe [2];
  logic [31:0] taddr [2], twd [2], texp [2];
  logic [2:0]  tlen [2];
  logic [31:0] mmem [2][16];

  // behavioural RAM attached to each arbiter
  logic [31:0] ram_mem [2][16];
  logic [31:0] pipe [2][4];
  logic [31:0] cap_addr [2], cap_wdata [2];
  logic        cap_wen [2];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic model_step(input int k);
    bit w;
    if (!rst_n) begin
      have[k] = 0; free_at[k] = edge_n + 1; starve[k] = 0;
      taddr[k] = '0; twd[k] = '0; tlen[k] = '0;
    end else begin
      if (edge_n >= free_at[k] && (m0_req || m1_req)) begin
        w = m1_req && (!m0_req || starve[k] >= 4);
        have[k] = 1; ts[k] = edge_n; w1[k] = w;
        twe[k]   = w ? m1_we : m0_we;
        taddr[k] = w ? m1_addr : m0_addr;
        twd[k]   = w ? m1_wdata : m0_wdata;
        tlen[k]  = w ? m1_len : m0_len;
        free_at[k] = edge_n + (twe[k] ? 2 : 2 + lat(k));
        if (twe[k]) mmem[k][taddr[k][5:2]] = twd[k];
        else texp[k] = mmem[k][taddr[k][5:2]];
        if (w) starve[k] = 0;
        else if (m1_req && starve[k] < 7) starve[k]++;
      end
      if (!m1_req) starve[k] = 0;
    end
  endtask

  task automatic ram_step(input int k);
    for (int i = 3; i > 0; i--) pipe[k][i] = pipe[k][i-1];
    pipe[k][0] = ram_mem[k][cap_addr[k][5:2]];
    if (cap_wen[k]) ram_mem[k][cap_addr[k][5:2]] = cap_wdata[k];
    ram_rd[k] = pipe[k][lat(k)-1];
  endtask

  task automatic check_all(input int k);
    int  off;
    bit  g, rv;
    off = edge_n - ts[k];
    g   = have[k] && off == 0;
    rv  = have[k] && !twe[k] && off == lat(k);
    check($sformatf("gnt0[%0d]", k), gnt0[k], g && !w1[k]);
    check($sformatf("gnt1[%0d]", k), gnt1[k], g && w1[k]);
    check($sformatf("wr_en[%0d]", k), wen[k], g && twe[k]);
    check($sformatf("rvalid0[%0d]", k), rv0[k], rv && !w1[k]);
    check($sformatf("rvalid1[%0d]", k), rv1[k], rv && w1[k]);
    check($sformatf("rdata0[%0d]", k), rd0[k], (rv && !w1[k]) ? texp[k] : 32'd0);
    check($sformatf("rdata1[%0d]", k), rd1[k], (rv && w1[k]) ? texp[k] : 32'd0);
    check($sformatf("busy[%0d]", k), busy[k], have[k] && off <= (twe[k] ? 0 : lat(k)));
    check($sformatf("address[%0d]", k), raddr[k], taddr[k]);
    check($sformatf("wr_data[%0d]", k), rwdata[k], twd[k]);
    check($sformatf("wr_len[%0d]", k), rlen[k], tlen[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    for (int k = 0; k < 2; k++) ram_step(k);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_all(k);
      cap_addr[k] = raddr[k]; cap_wdata[k] = rwdata[k]; cap_wen[k] = wen[k];
    end
  endtask

  // grant order seen on the latency-1 arbiter; bit i is 1 when grant i went to m1
  task automatic collect_grants(input int n, output logic [9:0] seq, output int got);
    seq = '0; got = 0;
    for (int c = 0; c < 100 && got < n; c++) begin
      tick();
      if (gnt0[0] || gnt1[0]) begin
        seq[got] = gnt1[0];
        got++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [9:0] seq, exp_seq;
    int         got;
    bit         seen;

    for (int k = 0; k < 2; k++) begin
      free_at[k] = 0; ts[k] = 0; starve[k] = 0; have[k] = 0; w1[k] = 0; twe[k] = 0;
      taddr[k] = '0; twd[k] = '0; tlen[k] = '0; texp[k] = '0;
      cap_addr[k] = '0; cap_wdata[k] = '0; cap_wen[k] = 0; ram_rd[k] = '0;
      for (int i = 0; i < 16; i++) begin mmem[k][i] = '0; ram_mem[k][i] = '0; end
      for (int i = 0; i < 4; i++) pipe[k][i] = '0;
    end

    // reset held with both masters requesting
    rst_n = 0;
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_len = 3'd2;
    m1_req = 1; m1_we = 0; m1_addr = 32'h30; m1_wdata = 32'h0; m1_len = 3'd0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    check("release_gnt_l1", gnt0[0], 1'b1);
    check("release_gnt_l3", gnt0[1], 1'b1);

    // m0 write then read-back of the same word
    m1_req = 0; m0_we = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = rv0[0];
    end
    if (!seen) timeout_fail("wait_m0_rvalid");
    else check("readback_l1", rd0[0], 32'hDEADBEEF);
    m0_req = 0;
    repeat (8) tick();

    // continuous contention: m1 forced through after four m0 grants
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0; m0_addr = 32'h10; m1_addr = 32'h30;
    collect_grants(10, seq, got);
    exp_seq = 10'b1000010000;
    if (got < 10) timeout_fail("contention_grants");
    for (int i = 0; i < 10; i++) check($sformatf("contention_grant%0d", i), seq[i], exp_seq[i]);
    m0_req = 0; m1_req = 0;
    repeat (8) tick();

    // m1 alone: write 0x20, then read it back
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_len = 3'd2;
    tick();
    m1_we = 0;
    seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      seen = rv1[1];
    end
    if (!seen) timeout_fail("wait_m1_rvalid");
    else check("m1_readback_l3", rd1[1], 32'h12345678);
    m1_req = 0;
    repeat (8) tick();

    // reset while the latency-3 arbiter is waiting for read data
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = busy[1] && !gnt0[1] && !gnt1[1];
    end
    if (!seen) timeout_fail("wait_rdwait");
    m0_req = 0; rst_n = 0;
    tick();
    check("rst_busy_l3", busy[1], 1'b0);
    rst_n = 1;
    repeat (6) tick();
    m0_req = 1; m0_we = 1; m0_addr = 32'h18; m0_wdata = 32'hA5A5_0F0F;
    tick();
    check("post_rst_gnt_l3", gnt0[1], 1'b1);
    m0_req = 0;
    repeat (8) tick();

    // m1 backs off after two losses; its starvation credit must restart
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
    collect_grants(2, seq, got);
    if (got < 2) timeout_fail("pre_drop_grants");
    m1_req = 0;
    tick();
    m1_req = 1;
    collect_grants(5, seq, got);
    exp_seq = 10'b0000010000;
    if (got < 5) timeout_fail("post_drop_grants");
    for (int i = 0; i < 5; i++) check($sformatf("post_drop_grant%0d", i), seq[i], exp_seq[i]);
    m0_req = 0; m1_req = 0;
    repeat (8) tick();

    // random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      m0_req   = ($urandom_range(0, 3) != 0);
      m1_req   = ($urandom_range(0, 3) != 0);
      m0_we    = $urandom_range(0, 1) == 1;
      m1_we    = $urandom_range(0, 1) == 1;
      m0_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      m1_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      m0_wdata = $urandom;
      m1_wdata = $urandom;
      m0_len   = 3'($urandom_range(0, 7));
      m1_len   = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
